// File: rtl/posit_err_pkg.sv
// rtl/posit_err_pkg.sv - shared FSM state type and constants for the posit error monitor
package posit_err_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int DRAIN_CYCLES = 2;
   localparam int HIST_BINS    = 4;

endpackage

// File: rtl/posit_lane_diff.sv
// rtl/posit_lane_diff.sv - one lane: absolute distance between two posit bit patterns
// and the over-tolerance flag.
module posit_lane_diff
   import posit_err_pkg::*;
#(
   parameter int N   = 8,
   parameter int TOL = 0
)(
   input  logic [N-1:0] act_i,
   input  logic [N-1:0] exp_i,
   output logic [N-1:0] diff_o,
   output logic         err_o
);

   localparam logic [32:0] TOL_U = 33'(TOL);

   assign diff_o = (exp_i >= act_i) ? (exp_i - act_i) : (act_i - exp_i);
   assign err_o  = 33'(diff_o) > TOL_U;

endmodule

// File: rtl/posit_err_monitor.sv
// rtl/posit_err_monitor.sv - two-stage posit result checker with saturating run statistics.
// Optional diff histogram output enabled by defining POSIT_ERR_HIST_EN.
module posit_err_monitor
   import posit_err_pkg::*;
#(
   parameter int N     = 8,
   parameter int LANES = 1,
   parameter int CNT_W = 32,
   parameter int TOL   = 0
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 in_valid,
   input  logic [LANES*N-1:0]   in_act,
   input  logic [LANES*N-1:0]   in_exp,
   output logic                 busy,
   output logic                 done,
   output logic                 err_flag,
   output logic [CNT_W-1:0]     beat_cnt,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [CNT_W-1:0]     sum_diff,
   output logic [N-1:0]         max_diff,
   output logic [CNT_W-1:0]     first_err_idx,
   output logic                 first_err_vld
`ifdef POSIT_ERR_HIST_EN
  ,output logic [HIST_BINS*CNT_W-1:0] hist
`endif
);

   localparam int              SW        = ((CNT_W > N + 2) ? CNT_W : N + 2) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [SW-1:0]   CNT_MAX_W = SW'(CNT_MAX);

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [N+1:0]     b);
      logic [SW-1:0] s;
      s = SW'(a) + SW'(b);
      return (s > CNT_MAX_W) ? CNT_MAX : s[CNT_W-1:0];
   endfunction

   state_e     state_q;
   logic [1:0] drain_q;
   logic       busy_q;
   logic       done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         drain_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (start) begin
         state_q <= ST_RUN;
         drain_q <= '0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: if (stop) begin
               state_q <= ST_DRAIN;
               drain_q <= '0;
            end
            ST_DRAIN: if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
               state_q <= ST_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end else begin
               drain_q <= drain_q + 2'd1;
            end
            default: ;
         endcase
      end
   end

   logic [LANES*N-1:0] diff_w;
   logic [LANES-1:0]   err_w;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      posit_lane_diff #(.N(N), .TOL(TOL)) u_lane (
         .act_i  (in_act[k*N +: N]),
         .exp_i  (in_exp[k*N +: N]),
         .diff_o (diff_w[k*N +: N]),
         .err_o  (err_w[k])
      );
   end

   // Stage 1: latch per-lane results of accepted beats.
   logic               s1_vld_q;
   logic [LANES*N-1:0] s1_diff_q;
   logic [LANES-1:0]   s1_err_q;
   logic               accept;

   assign accept = in_valid && (state_q == ST_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_diff_q <= '0;
         s1_err_q  <= '0;
      end else begin
         s1_vld_q <= accept;
         if (accept) begin
            s1_diff_q <= diff_w;
            s1_err_q  <= err_w;
         end
      end
   end

   logic [N+1:0] beat_sum;
   logic [N-1:0] beat_max;
   logic [N+1:0] beat_nerr;

   always_comb begin
      beat_sum  = '0;
      beat_max  = '0;
      beat_nerr = '0;
      for (int k = 0; k < LANES; k++) begin
         beat_sum  = beat_sum + {2'b00, s1_diff_q[k*N +: N]};
         beat_nerr = beat_nerr + (N+2)'(s1_err_q[k]);
         if (s1_diff_q[k*N +: N] > beat_max) beat_max = s1_diff_q[k*N +: N];
      end
   end

   // Stage 2: fold the registered beat into the run statistics.
   logic [CNT_W-1:0] beat_q, beat_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [CNT_W-1:0] sum_q, sum_d;
   logic [N-1:0]     max_q, max_d;
   logic [CNT_W-1:0] fidx_q, fidx_d;
   logic             fvld_q, fvld_d;

   always_comb begin
      beat_d = beat_q;
      err_d  = err_q;
      sum_d  = sum_q;
      max_d  = max_q;
      fidx_d = fidx_q;
      fvld_d = fvld_q;
      if (s1_vld_q) begin
         beat_d = sat_add(beat_q, (N+2)'(1));
         err_d  = sat_add(err_q, beat_nerr);
         sum_d  = sat_add(sum_q, beat_sum);
         max_d  = (beat_max > max_q) ? beat_max : max_q;
         if (|s1_err_q && !fvld_q) begin
            fidx_d = beat_q;
            fvld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || start) begin
         beat_q <= '0;
         err_q  <= '0;
         sum_q  <= '0;
         max_q  <= '0;
         fidx_q <= '0;
         fvld_q <= 1'b0;
      end else begin
         beat_q <= beat_d;
         err_q  <= err_d;
         sum_q  <= sum_d;
         max_q  <= max_d;
         fidx_q <= fidx_d;
         fvld_q <= fvld_d;
      end
   end

`ifdef POSIT_ERR_HIST_EN
   logic [HIST_BINS*CNT_W-1:0]   hist_q, hist_d;
   logic [HIST_BINS-1:0][N+1:0]  bin_n;

   always_comb begin
      bin_n  = '0;
      hist_d = hist_q;
      for (int k = 0; k < LANES; k++) begin
         if (s1_diff_q[k*N +: N] > N'(2)) bin_n[3] = bin_n[3] + (N+2)'(1);
         else bin_n[s1_diff_q[k*N +: 2]] = bin_n[s1_diff_q[k*N +: 2]] + (N+2)'(1);
      end
      if (s1_vld_q) begin
         for (int b = 0; b < HIST_BINS; b++)
            hist_d[b*CNT_W +: CNT_W] = sat_add(hist_q[b*CNT_W +: CNT_W], bin_n[b]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || start) hist_q <= '0;
      else              hist_q <= hist_d;
   end

   assign hist = hist_q;
`endif

   assign busy          = busy_q;
   assign done          = done_q;
   assign beat_cnt      = beat_q;
   assign err_cnt       = err_q;
   assign sum_diff      = sum_q;
   assign max_diff      = max_q;
   assign first_err_idx = fidx_q;
   assign first_err_vld = fvld_q;
   assign err_flag      = |err_q;

endmodule

// File: doc/posit_err_monitor.md
POSIT_ERR_MONITOR -- requirements
Module: posit_err_monitor

Interface
REQ-001 SHALL have parameter N, default 8, posit word width in bits (4..32).
REQ-002 SHALL have parameter LANES, default 1, result pairs checked per beat (1..4).
REQ-003 SHALL have parameter CNT_W, default 32, width of every counter/accumulator.
REQ-004 SHALL have parameter TOL, default 0, largest diff not counted as an error.
REQ-005 SHALL have ports: clk input 1, the single clock; rst input 1, synchronous active-high reset.
REQ-006 SHALL have ports: start input 1, open run and clear stats; stop input 1, close run.
REQ-007 SHALL have ports: in_valid input 1, beat qualifier; in_act input LANES*N, DUT outputs; in_exp input LANES*N, golden results. Lane k occupies bits [k*N +: N].
REQ-008 SHALL have ports: busy output 1; done output 1; err_flag output 1, at least one error seen.
REQ-009 SHALL have ports: beat_cnt output CNT_W; err_cnt output CNT_W; sum_diff output CNT_W; max_diff output N.
REQ-010 SHALL have ports: first_err_idx output CNT_W, beat index of the first error; first_err_vld output 1.

Function
REQ-011 Per lane diff SHALL be |exp - act|, with both operands read as N-bit unsigned patterns, giving an N-bit result.
REQ-012 A lane SHALL count as an error when diff > TOL.
REQ-013 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-014 FSM transitions SHALL be:
- start in any state -> RUN.
- stop in RUN -> DRAIN.
- DRAIN lasts exactly 2 cycles -> DONE.
- DONE holds until start.
REQ-015 start SHALL clear all statistics in the same cycle. start and stop asserted together SHALL be treated as start only.
REQ-016 Beats SHALL be accepted only when in_valid=1 and state=RUN. Beats in every other state SHALL be ignored. There is no backpressure.
REQ-017 The pipeline SHALL have 2 stages: stage 1 registers the diffs and error bits; stage 2 updates the statistics. A beat accepted in cycle t SHALL be visible on the outputs in cycle t+2.
REQ-018 A beat accepted in the stop cycle SHALL be counted. DRAIN SHALL ensure every accepted beat is reflected before done rises.
REQ-019 Per accepted beat:
- beat_cnt += 1.
- err_cnt += number of erroring lanes.
- sum_diff += sum of all lane diffs.
- max_diff = max(max_diff, all lane diffs).
REQ-020 All counters SHALL saturate at all-ones and never wrap. sum_diff SHALL saturate if the addition would overflow.
REQ-021 first_err_idx SHALL capture the beat_cnt value (pre-increment) of the first beat that has any erroring lane, and SHALL then set first_err_vld. Later errors SHALL NOT overwrite it.
REQ-022 busy SHALL be 1 in RUN and DRAIN. done SHALL be 1 in DONE only. err_flag SHALL equal (err_cnt != 0).
REQ-023 Statistics SHALL hold their values in DONE and IDLE.

Reset
REQ-024 rst SHALL force state IDLE and clear both pipeline stages.
REQ-025 On rst, every output SHALL go to 0.
REQ-026 rst during RUN or DRAIN SHALL discard in-flight beats. rst SHALL have priority over start.

Configuration
REQ-027 With POSIT_ERR_HIST_EN defined, the block SHALL add output hist, width 4*CNT_W, holding saturating counters of lane diffs in bins 0, 1, 2, >=3 (bin b at [b*CNT_W +: CNT_W]). These bins SHALL be cleared by start and rst.
REQ-028 Without POSIT_ERR_HIST_EN, the hist port and its logic SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-029 A shared package posit_err_pkg SHALL hold the FSM state enum, the DRAIN_CYCLES=2 constant and the histogram bin count 4.
REQ-030 A sub-module posit_lane_diff SHALL compute per-lane diff and error bit combinationally, instantiated LANES times. The reduction and statistics SHALL live in the top.

Verification
REQ-031 Scenario: N=8, LANES=1; start; beats (act,exp)=(0x40,0x40),(0x41,0x40),(0x3C,0x40); stop -> beat_cnt=3, err_cnt=2, sum_diff=5, max_diff=4, first_err_idx=1, done rises 2 cycles after stop.
REQ-032 Scenario: TOL=1, same stream -> err_cnt=1, first_err_idx=2.
REQ-033 Scenario: LANES=4, one beat with diffs 0,3,0,7 -> err_cnt=2, sum_diff=10, max_diff=7. With POSIT_ERR_HIST_EN -> hist bins 2,0,0,2.
REQ-034 Scenario: CNT_W=4; 20 beats each with diff 1 -> beat_cnt=15, err_cnt=15, sum_diff=15 (saturated).
REQ-035 Scenario: rst asserted one cycle after an erroring beat in RUN -> all outputs 0 next cycle; a later start/stop with no beats -> done=1, err_flag=0.
REQ-036 Scenario: start and stop asserted together in DONE -> state RUN, stats cleared; in_valid beats outside RUN -> no counter change.
